axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares the single read request/response channel of the AXI shim between
//  NumReq read clients (e.g. icache, dcache, PTW). Round-robin arbitration on
//  request, requester index encoded in the AXI ID MSBs, responses routed back
//  by ID. Per-client outstanding-burst limits; exclusive (lock) reads block
//  other clients until the locked burst completes.
// PARAMETERS
//  NumReq          3   number of read clients (>=2)
//  AxiAddrWidth    64  address width
//  AxiDataWidth    64  data width
//  AxiUserWidth    1   user width
//  AxiIdWidth      4   shim ID width; IdxW=$clog2(NumReq), SubIdW=AxiIdWidth-IdxW (>=1)
//  MaxOutstanding  4   max in-flight bursts per client (cnt width $clog2(MaxOutstanding+1))
// PORTS
//  clk_i           in   1                   clock
//  rst_i           in   1                   synchronous reset, active-high
//  req_valid_i     in   NumReq              client read request
//  req_addr_i      in   NumReq*AxiAddrWidth request address
//  req_blen_i      in   NumReq*8            burst length-1
//  req_size_i      in   NumReq*3            beat size
//  req_id_i        in   NumReq*SubIdW       client-local ID
//  req_lock_i      in   NumReq              exclusive read
//  req_gnt_o       out  NumReq              request accepted (1-cycle pulse)
//  rsp_rdy_i       in   NumReq              client ready for data
//  rsp_valid_o     out  NumReq              data beat valid
//  rsp_last_o      out  1                   last beat (shared)
//  rsp_data_o      out  AxiDataWidth        data (shared)
//  rsp_user_o      out  AxiUserWidth        user (shared)
//  rsp_id_o        out  SubIdW              client-local ID (shared)
//  rsp_exokay_o    out  1                   exclusive okay (shared)
//  shim_rd_req_o   out  1                   to shim rd_req_i
//  shim_rd_gnt_i   in   1                   from shim rd_gnt_o
//  shim_rd_addr_o/blen_o/size_o/lock_o  out as client  muxed request fields
//  shim_rd_id_o    out  AxiIdWidth          {idx, client id}
//  shim_rd_valid_i/last_i/data_i/user_i/id_i/exokay_i  in  response from shim
//  shim_rd_rdy_o   out  1                   to shim rd_rdy_i
//  err_o           out  1                   sticky: bad response index or count underflow
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, all cnt=0, err_o=0, req_gnt_o=0, shim_rd_req_o=0.
//  Eligible[i] = req_valid_i[i] & cnt[i]<MaxOutstanding.
//  FSM IDLE: if any eligible, pick first eligible at/after rr_ptr (cyclic),
//   latch sel_idx -> ISSUE next cycle. No eligible: stay.
//  ISSUE: shim_rd_req_o=1; fields combinationally muxed from client sel_idx;
//   shim_rd_id_o={sel_idx,req_id_i[sel_idx]}. Client must hold fields stable
//   until gnt. On shim_rd_gnt_i: req_gnt_o[sel_idx]=1 same cycle, cnt++,
//   rr_ptr=(sel_idx+1) mod NumReq; next = LOCKED if lock else IDLE.
//   Min request latency: valid at cycle N -> shim_rd_req_o at N+1.
//  LOCKED: no new grants; return to IDLE on the cycle the locked client's
//   last beat handshakes (valid&rdy&last with matching idx).
//  Response routing (all states): ridx=shim_rd_id_i[MSBs]; if ridx<NumReq:
//   rsp_valid_o[ridx]=shim_rd_valid_i, shim_rd_rdy_o=rsp_rdy_i[ridx];
//   else shim_rd_rdy_o=1 (beat dropped), err_o set. Zero added latency.
//  cnt[i]-- on valid&rdy&last for ridx=i; same-cycle grant+completion for the
//   same client leaves cnt unchanged. Decrement at cnt=0: hold 0, set err_o.
//  Reset mid-burst: all state cleared; subsequent late beats still routed.
// TESTING
//  1. Reset: rst_i high 2 cycles -> all outputs 0, err_o=0, FSM IDLE.
//  2. Clients 0,1,2 request continuously, shim gnt each ISSUE -> grant order
//     0,1,2,0,1,2; shim_rd_id_o MSBs match.
//  3. Client 1 issues 4 bursts, no responses -> 5th request not granted, others
//     still served; one last beat id={1,x} -> client 1 granted again.
//  4. Client 0 lock read -> no grants until its blen=3 burst's 4th beat
//     handshakes; client 2 granted next cycle after.
//  5. rsp_rdy_i[2]=0 with beat id={2,5} -> shim_rd_rdy_o=0, data held; rdy=1
//     -> rsp_valid_o=3'b100, rsp_id_o=5.
//  6. Response id MSBs=3 (NumReq=3) -> shim_rd_rdy_o=1, no rsp_valid_o, err_o=1.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares the single read request/response channel of the AXI shim between
// NumReq read clients. Requests are arbitrated round-robin. The winning client
// index is placed in the MSBs of the shim read ID, and responses are routed back
// to the client by those ID MSBs. Each client has a limit on in-flight bursts.
// An exclusive (lock) read blocks all further grants until the locked burst's
// last beat has been accepted.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_*_i / req_gnt_o      per-client request fields (packed, client i at
//                            slice i) and one-cycle grant pulse
//   rsp_rdy_i / rsp_valid_o  per-client response handshake
//   rsp_last/data/user/id/exokay_o  shared response fields
//   shim_rd_req_o/gnt_i, shim_rd_addr/blen/size/lock/id_o  request to the shim
//   shim_rd_valid/last/data/user/id/exokay_i, shim_rd_rdy_o  response from shim
//   err_o                    sticky: response with a bad index, or a count
//                            underflow
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int NumReq         = 3,
    parameter int AxiAddrWidth   = 64,
    parameter int AxiDataWidth   = 64,
    parameter int AxiUserWidth   = 1,
    parameter int AxiIdWidth     = 4,
    parameter int MaxOutstanding = 4,
    localparam int IdxW          = $clog2(NumReq),
    localparam int SubIdW        = AxiIdWidth - IdxW,
    localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    // client requests
    input  logic [NumReq-1:0]            req_valid_i,
    input  logic [NumReq*AxiAddrWidth-1:0] req_addr_i,
    input  logic [NumReq*8-1:0]          req_blen_i,
    input  logic [NumReq*3-1:0]          req_size_i,
    input  logic [NumReq*SubIdW-1:0]     req_id_i,
    input  logic [NumReq-1:0]            req_lock_i,
    output logic [NumReq-1:0]            req_gnt_o,
    // client responses
    input  logic [NumReq-1:0]            rsp_rdy_i,
    output logic [NumReq-1:0]            rsp_valid_o,
    output logic                         rsp_last_o,
    output logic [AxiDataWidth-1:0]      rsp_data_o,
    output logic [AxiUserWidth-1:0]      rsp_user_o,
    output logic [SubIdW-1:0]            rsp_id_o,
    output logic                         rsp_exokay_o,
    // shim request
    output logic                         shim_rd_req_o,
    input  logic                         shim_rd_gnt_i,
    output logic [AxiAddrWidth-1:0]      shim_rd_addr_o,
    output logic [7:0]                   shim_rd_blen_o,
    output logic [2:0]                   shim_rd_size_o,
    output logic                         shim_rd_lock_o,
    output logic [AxiIdWidth-1:0]        shim_rd_id_o,
    // shim response
    input  logic                         shim_rd_valid_i,
    input  logic                         shim_rd_last_i,
    input  logic [AxiDataWidth-1:0]      shim_rd_data_i,
    input  logic [AxiUserWidth-1:0]      shim_rd_user_i,
    input  logic [AxiIdWidth-1:0]        shim_rd_id_i,
    input  logic                         shim_rd_exokay_i,
    output logic                         shim_rd_rdy_o,
    output logic                         err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   sel_idx_q, sel_idx_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]   cnt_q [NumReq];
    logic [CntW-1:0]   cnt_d [NumReq];
    logic              err_q, err_d;

    logic [NumReq-1:0] eligible;
    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;
    logic [IdxW-1:0]   cand_idx;
    logic [IdxW-1:0]   ridx;
    logic              ridx_ok;
    logic              beat_done;
    logic              grant;
    logic              sel_lock;
    logic [NumReq-1:0] inc_v;
    logic [NumReq-1:0] dec_v;

    // Shared response fields pass straight through; only valid/ready are routed.
    assign rsp_last_o   = shim_rd_last_i;
    assign rsp_data_o   = shim_rd_data_i;
    assign rsp_user_o   = shim_rd_user_i;
    assign rsp_id_o     = shim_rd_id_i[SubIdW-1:0];
    assign rsp_exokay_o = shim_rd_exokay_i;
    assign err_o        = err_q;

    assign ridx = shim_rd_id_i[AxiIdWidth-1 -: IdxW];

    // Response routing. An index with no client behind it is sunk (ready=1)
    // so the shim never stalls on a beat nobody will accept.
    always_comb begin
        rsp_valid_o   = '0;
        shim_rd_rdy_o = 1'b1;
        ridx_ok       = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (ridx == IdxW'(i)) begin
                ridx_ok        = 1'b1;
                rsp_valid_o[i] = shim_rd_valid_i;
                shim_rd_rdy_o  = rsp_rdy_i[i];
            end
        end
    end

    assign beat_done = shim_rd_valid_i & shim_rd_rdy_o & shim_rd_last_i & ridx_ok;

    // Round-robin pick: first eligible client at or after rr_ptr, cyclically.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] && (cnt_q[i] < CntW'(MaxOutstanding));
        end
        for (int k = 0; k < NumReq; k++) begin
            cand_idx = IdxW'((int'(rr_ptr_q) + k) % NumReq);
            if (!pick_found && eligible[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Request field mux for the selected client; zero while not issuing.
    always_comb begin
        shim_rd_addr_o = '0;
        shim_rd_blen_o = '0;
        shim_rd_size_o = '0;
        shim_rd_lock_o = 1'b0;
        shim_rd_id_o   = '0;
        sel_lock       = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (sel_idx_q == IdxW'(i)) begin
                sel_lock = req_lock_i[i];
                if (state_q == ISSUE) begin
                    shim_rd_addr_o = req_addr_i[i*AxiAddrWidth +: AxiAddrWidth];
                    shim_rd_blen_o = req_blen_i[i*8 +: 8];
                    shim_rd_size_o = req_size_i[i*3 +: 3];
                    shim_rd_lock_o = req_lock_i[i];
                    shim_rd_id_o   = {sel_idx_q, req_id_i[i*SubIdW +: SubIdW]};
                end
            end
        end
    end

    // Arbitration FSM next-state and outputs.
    always_comb begin
        state_d       = state_q;
        sel_idx_d     = sel_idx_q;
        rr_ptr_d      = rr_ptr_q;
        shim_rd_req_o = 1'b0;
        req_gnt_o     = '0;
        grant         = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_idx_d = pick_idx;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                shim_rd_req_o = 1'b1;
                if (shim_rd_gnt_i) begin
                    grant = 1'b1;
                    for (int i = 0; i < NumReq; i++) begin
                        req_gnt_o[i] = (sel_idx_q == IdxW'(i));
                    end
                    rr_ptr_d = (sel_idx_q == IdxW'(NumReq - 1)) ? '0 : sel_idx_q + IdxW'(1);
                    state_d  = sel_lock ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                // sel_idx_q still names the locked client here.
                if (beat_done && (ridx == sel_idx_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding-burst counters. Grant and completion on the same client in
    // the same cycle cancel out.
    always_comb begin
        err_d = err_q;
        if (shim_rd_valid_i && !ridx_ok) begin
            err_d = 1'b1;
        end
        for (int i = 0; i < NumReq; i++) begin
            inc_v[i] = grant && (sel_idx_q == IdxW'(i));
            dec_v[i] = beat_done && (ridx == IdxW'(i));
            cnt_d[i] = cnt_q[i];
            if (inc_v[i] && !dec_v[i]) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (dec_v[i] && !inc_v[i]) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sel_idx_q <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < NumReq; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            sel_idx_q <= sel_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
            for (int i = 0; i < NumReq; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Directed scenarios followed by a randomized phase. Expected grants come from
// a reference model holding per-client outstanding counts and a round-robin
// pointer as plain integers.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    localparam int N  = 3;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int UW = 1;
    localparam int IW = 5;
    localparam int MO = 4;
    localparam int XW = 2;
    localparam int SW = IW - XW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_i;
    logic [N-1:0]      req_valid_i, req_lock_i, req_gnt_o, rsp_rdy_i, rsp_valid_o;
    logic [N*AW-1:0]   req_addr_i;
    logic [N*8-1:0]    req_blen_i;
    logic [N*3-1:0]    req_size_i;
    logic [N*SW-1:0]   req_id_i;
    logic              rsp_last_o, rsp_exokay_o;
    logic [DW-1:0]     rsp_data_o;
    logic [UW-1:0]     rsp_user_o;
    logic [SW-1:0]     rsp_id_o;
    logic              shim_rd_req_o, shim_rd_gnt_i;
    logic [AW-1:0]     shim_rd_addr_o;
    logic [7:0]        shim_rd_blen_o;
    logic [2:0]        shim_rd_size_o;
    logic              shim_rd_lock_o;
    logic [IW-1:0]     shim_rd_id_o;
    logic              shim_rd_valid_i, shim_rd_last_i, shim_rd_exokay_i, shim_rd_rdy_o;
    logic [DW-1:0]     shim_rd_data_i;
    logic [UW-1:0]     shim_rd_user_i;
    logic [IW-1:0]     shim_rd_id_i;
    logic              err_o;

    axi_rd_arbiter #(
        .NumReq(N), .AxiAddrWidth(AW), .AxiDataWidth(DW), .AxiUserWidth(UW),
        .AxiIdWidth(IW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_blen_i(req_blen_i),
        .req_size_i(req_size_i), .req_id_i(req_id_i), .req_lock_i(req_lock_i),
        .req_gnt_o(req_gnt_o),
        .rsp_rdy_i(rsp_rdy_i), .rsp_valid_o(rsp_valid_o), .rsp_last_o(rsp_last_o),
        .rsp_data_o(rsp_data_o), .rsp_user_o(rsp_user_o), .rsp_id_o(rsp_id_o),
        .rsp_exokay_o(rsp_exokay_o),
        .shim_rd_req_o(shim_rd_req_o), .shim_rd_gnt_i(shim_rd_gnt_i),
        .shim_rd_addr_o(shim_rd_addr_o), .shim_rd_blen_o(shim_rd_blen_o),
        .shim_rd_size_o(shim_rd_size_o), .shim_rd_lock_o(shim_rd_lock_o),
        .shim_rd_id_o(shim_rd_id_o),
        .shim_rd_valid_i(shim_rd_valid_i), .shim_rd_last_i(shim_rd_last_i),
        .shim_rd_data_i(shim_rd_data_i), .shim_rd_user_i(shim_rd_user_i),
        .shim_rd_id_i(shim_rd_id_i), .shim_rd_exokay_i(shim_rd_exokay_i),
        .shim_rd_rdy_o(shim_rd_rdy_o), .err_o(err_o)
    );

    int checks = 0;
    int errors = 0;

    // reference model
    int m_cnt [N];
    int m_rr;
    bit m_err;

    // per-client request fields
    logic [AW-1:0] c_addr [N];
    logic [7:0]    c_blen [N];
    logic [2:0]    c_size [N];
    logic [SW-1:0] c_id   [N];
    logic [N-1:0]  c_lock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (mask[i] && m_cnt[i] < MO) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_rr  = 0;
        m_err = 1'b0;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            c_addr[i] = {$urandom, $urandom};
            c_blen[i] = 8'($urandom);
            c_size[i] = 3'($urandom);
            c_id[i]   = SW'($urandom);
        end
        c_lock = '0;
    endtask

    task automatic drive_req(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW] = c_addr[i];
            req_blen_i[i*8 +: 8]   = c_blen[i];
            req_size_i[i*3 +: 3]   = c_size[i];
            req_id_i[i*SW +: SW]   = c_id[i];
        end
        req_lock_i  = c_lock;
        req_valid_i = mask;
    endtask

    // Wait for the issue of client exp, check the muxed fields, then grant it.
    // with_beat lands a last beat for the same client in the grant cycle.
    task automatic grant_one(input int exp, input bit with_beat);
        int n;
        bit beat;
        n = 0;
        while (shim_rd_req_o !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("issue_wait", 64'(n < 20), 64'(1));
        chk("issue_idx", 64'(shim_rd_id_o[IW-1 -: XW]), 64'(exp));
        chk("issue_subid", 64'(shim_rd_id_o[SW-1:0]), 64'(c_id[exp]));
        chk("issue_addr", shim_rd_addr_o, c_addr[exp]);
        chk("issue_blen", 64'(shim_rd_blen_o), 64'(c_blen[exp]));
        chk("issue_size", 64'(shim_rd_size_o), 64'(c_size[exp]));
        chk("issue_lock", 64'(shim_rd_lock_o), 64'(c_lock[exp]));
        chk("gnt_early", 64'(req_gnt_o), 64'(0));
        beat = with_beat && (m_cnt[exp] > 0);
        shim_rd_gnt_i = 1'b1;
        if (beat) begin
            shim_rd_valid_i = 1'b1;
            shim_rd_last_i  = 1'b1;
            shim_rd_id_i    = {XW'(exp), SW'(0)};
            rsp_rdy_i       = N'(1) << exp;
        end
        #1;
        chk("gnt_pulse", 64'(req_gnt_o), 64'(N'(1) << exp));
        cyc();
        shim_rd_gnt_i   = 1'b0;
        shim_rd_valid_i = 1'b0;
        shim_rd_last_i  = 1'b0;
        rsp_rdy_i       = '0;
        if (!beat) m_cnt[exp]++;
        m_rr = (exp + 1) % N;
    endtask

    task automatic send_beat(input int idx, input logic [SW-1:0] sub, input bit last,
                             input logic [N-1:0] rdy);
        logic [DW-1:0] d;
        logic [N-1:0]  ev;
        logic          er;
        d = {$urandom, $urandom};
        shim_rd_valid_i  = 1'b1;
        shim_rd_id_i     = {XW'(idx), sub};
        shim_rd_last_i   = last;
        shim_rd_data_i   = d;
        shim_rd_exokay_i = 1'($urandom);
        rsp_rdy_i        = rdy;
        if (idx < N) begin
            ev = N'(1) << idx;
            er = rdy[idx];
        end else begin
            ev = '0;
            er = 1'b1;
        end
        #1;
        chk("rsp_valid", 64'(rsp_valid_o), 64'(ev));
        chk("shim_rdy", 64'(shim_rd_rdy_o), 64'(er));
        chk("rsp_data", rsp_data_o, d);
        chk("rsp_id", 64'(rsp_id_o), 64'(sub));
        chk("rsp_last", 64'(rsp_last_o), 64'(last));
        cyc();
        shim_rd_valid_i = 1'b0;
        shim_rd_last_i  = 1'b0;
        rsp_rdy_i       = '0;
        if (idx >= N) m_err = 1'b1;
        else if (rdy[idx] && last) begin
            if (m_cnt[idx] == 0) m_err = 1'b1;
            else m_cnt[idx]--;
        end
        chk("err_o", 64'(err_o), 64'(m_err));
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) begin
            while (m_cnt[i] > 0) send_beat(i, SW'($urandom), 1'b1, N'(1) << i);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [N-1:0] mask;
        logic [DW-1:0] hd;

        rst_i = 1'b1;
        req_valid_i = '0; req_lock_i = '0; req_addr_i = '0; req_blen_i = '0;
        req_size_i = '0; req_id_i = '0; rsp_rdy_i = '0;
        shim_rd_gnt_i = 1'b0; shim_rd_valid_i = 1'b0; shim_rd_last_i = 1'b0;
        shim_rd_data_i = '0; shim_rd_user_i = '0; shim_rd_id_i = '0; shim_rd_exokay_i = 1'b0;
        model_reset();

        // 1. reset
        cyc();
        cyc();
        chk("rst_gnt", 64'(req_gnt_o), 64'(0));
        chk("rst_req", 64'(shim_rd_req_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("rst_addr", shim_rd_addr_o, 64'(0));
        rst_i = 1'b0;

        // 2. round robin with all clients requesting
        rand_fields();
        drive_req(3'b111);
        #1;
        chk("latency_pre", 64'(shim_rd_req_o), 64'(0));
        cyc();
        chk("latency", 64'(shim_rd_req_o), 64'(1));
        for (int g = 0; g < 6; g++) begin
            grant_one(g % N, 1'b0);
            rand_fields();
            drive_req(3'b111);
        end
        drive_req('0);
        drain();

        // 3. outstanding limit on client 1
        for (int k = 0; k < 4; k++) begin
            drive_req(3'b010);
            grant_one(1, 1'b0);
        end
        drive_req(3'b010);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("limit_block", 64'(shim_rd_req_o), 64'(0));
        end
        for (int k = 0; k < 3; k++) begin
            drive_req(3'b111);
            e = m_pick(3'b111);
            grant_one(e, 1'b0);
        end
        drive_req('0);
        send_beat(1, SW'($urandom), 1'b1, 3'b010);
        drive_req(3'b010);
        grant_one(1, 1'b0);
        drive_req('0);
        drain();

        // 4. exclusive read by client 0 blocks client 2
        rand_fields();
        c_lock[0] = 1'b1;
        c_blen[0] = 8'd3;
        drive_req(3'b001);
        grant_one(0, 1'b0);
        c_lock = '0;
        drive_req(3'b100);
        cyc();
        chk("lock_hold", 64'(shim_rd_req_o), 64'(0));
        for (int b = 0; b < 3; b++) begin
            send_beat(0, SW'($urandom), 1'b0, 3'b001);
            chk("lock_hold_beat", 64'(shim_rd_req_o), 64'(0));
        end
        send_beat(0, SW'($urandom), 1'b1, 3'b001);
        chk("unlock_idle", 64'(shim_rd_req_o), 64'(0));
        cyc();
        chk("unlock_issue", 64'(shim_rd_req_o), 64'(1));
        grant_one(2, 1'b0);
        drive_req('0);
        drain();

        // 5. backpressure from client 2
        drive_req(3'b100);
        grant_one(2, 1'b0);
        drive_req('0);
        hd = {$urandom, $urandom};
        shim_rd_valid_i = 1'b1;
        shim_rd_last_i  = 1'b1;
        shim_rd_id_i    = {2'd2, 3'd5};
        shim_rd_data_i  = hd;
        rsp_rdy_i       = 3'b011;
        #1;
        chk("bp_rdy", 64'(shim_rd_rdy_o), 64'(0));
        chk("bp_valid", 64'(rsp_valid_o), 64'(3'b100));
        cyc();
        chk("bp_held_rdy", 64'(shim_rd_rdy_o), 64'(0));
        chk("bp_data", rsp_data_o, hd);
        send_beat(2, 3'd5, 1'b1, 3'b100);
        chk("bp_err", 64'(err_o), 64'(0));

        // 6. response index with no client
        send_beat(3, SW'($urandom), 1'b1, 3'b111);

        // 7. reset mid-burst, late beats still routed, underflow flagged
        drive_req(3'b001);
        grant_one(0, 1'b0);
        drive_req('0);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        model_reset();
        chk("rst2_err", 64'(err_o), 64'(0));
        chk("rst2_req", 64'(shim_rd_req_o), 64'(0));
        send_beat(0, 3'd1, 1'b0, 3'b001);
        send_beat(0, 3'd1, 1'b1, 3'b001);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        model_reset();

        // randomized phase
        for (int it = 0; it < 80; it++) begin
            rand_fields();
            mask = N'($urandom_range(0, 7));
            drive_req(mask);
            e = m_pick(mask);
            if (e >= 0) begin
                grant_one(e, 1'($urandom_range(0, 1)));
            end else begin
                cyc();
                cyc();
                chk("rand_idle", 64'(shim_rd_req_o), 64'(0));
            end
            drive_req('0);
            if ($urandom_range(0, 99) < 45) begin
                int c;
                c = int'($urandom_range(0, N - 1));
                if (m_cnt[c] > 0)
                    send_beat(c, SW'($urandom), 1'($urandom_range(0, 1)), N'($urandom_range(0, 7)));
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
